spi_apb_bridge_ctrl: RTL and testbench
======================================

// Module: spi_apb_bridge_ctrl
// PURPOSE
// - Control FSM between the SPI slave deserialiser and an APB3 master port. Turns decoded
//   address/status/data frames into APB transfers to one of NSLV slaves.
// - Next generation of the single-pair bridge control: adds data/address width parameters,
//   N-way slave select, per-transfer timeout and an error code.
// - Never abandons an APB access phase before pready or timeout.
// PARAMETERS
// ADDR_W   20        APB address width; paddr increments wrap modulo 2^ADDR_W
// DATA_W   16        APB data width (multiple of 8); the step is DATA_W/8 per beat
// NSLV     2         number of APB slaves; psel is one-hot, SEL_W = max(1,$clog2(NSLV))
// TMO      64        max access-phase cycles with pready low before timeout (>=2)
// ERR_WORD 16'h4552  rdata value presented while in ERROR (zero-extended to DATA_W)
// PORTS
// clk            in   1            system clock
// reset_n        in   1            async active-low reset
// address_ready  in   1            1-cycle pulse: addr valid
// status_ready   in   1            1-cycle pulse: status valid, starts a command
// data_ready     in   1            1-cycle pulse: wdata valid (write) / rdata consumed (read)
// addr           in   ADDR_W       start address
// status         in   SEL_W+2      [SEL_W+1]=write, [SEL_W]=burst, [SEL_W-1:0]=slave index
// wdata          in   DATA_W       write data
// cs_n_o         in   1            SPI chip select (high = frame ended)
// miso_start     in   1            serialiser began shifting out rdata
// pready         in   1            APB ready (from the selected slave, muxed externally)
// prdata         in   DATA_W       APB read data
// pslverr        in   NSLV         per-slave error; only the selected bit is honoured
// psel           out  NSLV         one-hot APB select
// penable        out  1            APB enable
// pwrite         out  1            APB direction
// pstrb          out  DATA_W/8     byte strobes, all ones
// paddr          out  ADDR_W       APB address
// pwdata         out  DATA_W       APB write data
// rdata          out  DATA_W       data to the MISO serialiser
// err            out  1            1-cycle pulse on ERROR entry
// err_code       out  2            sticky until next status_ready: 00 none, 01 slverr/decode,
//                                  10 timeout, 11 read underrun
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; addr reg 0; cs_flag 0; timeout counter 0.
// - Outputs registered from next-state: valid in the same cycle the FSM enters a state.
// - cs_flag: cleared in IDLE, set when cs_n_o=1 in any other state. Checked only in WAIT_*/ERROR
//   and after access completion.
// - Address: loaded on address_ready (priority), else += DATA_W/8 on pready in ACCESS_*.
// - IDLE: on status_ready, clear err_code. If index>=NSLV -> ERROR (01). Else write -> WAIT_WR,
//   read -> SETUP_RD.
// - WAIT_WR: cs_flag -> IDLE; data_ready -> SETUP_WR.
// - SETUP_*: psel[index]=1, penable=0, paddr/pwdata/pwrite loaded; next cycle ACCESS_*.
// - ACCESS_*: penable=1, count cycles. On pready with pslverr[index] -> ERROR(01).
//   On pready without error: rd -> WAIT_RD and latch prdata; wr -> WAIT_WR if burst & !cs_flag,
//   else IDLE. Counter reaching TMO-1 without pready -> ERROR(10), psel/penable drop.
// - ACCESS_RD with miso_start & !pready -> ERROR(11); the access is still held until pready or
//   timeout, with an internal flag.
// - WAIT_RD: psel=0; cs_flag -> IDLE; data_ready -> SETUP_RD if burst, else IDLE.
// - ERROR: rdata=ERR_WORD, psel=penable=0. cs_flag -> IDLE. data_ready & burst -> SETUP_WR/RD
//   by write bit; data_ready & !burst -> IDLE.
// - Simultaneous pready and timeout terminal count: pready wins.
// - Simultaneous pready and address_ready: address_ready wins.
// - reset_n low mid-access: psel/penable drop asynchronously; no completion is reported.
// STRUCTURE
// - spi_bridge_pkg: state encodings, ERR_* codes, status field index localparams.
// - Sub-module apb_tmo_cnt (TMO param; clr, en -> expired): instanced once.
// - FSM, address and output registers stay in this module.
// TESTING
// - Single write, NSLV=4, idx 2, addr 0x00100, wdata 0xA5A5 -> psel=0100 for 2 cycles, paddr
//   0x00100, penable in the 2nd cycle, then IDLE.
// - Burst read x3 from 0x00010, pready delayed 3 cycles -> paddr 0x10/0x12/0x14, rdata =
//   each prdata, psel low in WAIT_RD.
// - pslverr[1] on idx 1 write -> err pulse 1 cycle, err_code=01, rdata=0x4552, next data_ready
//   with burst -> SETUP_WR at addr+2.
// - pready held low, TMO=8 -> ERROR after 8 access cycles, err_code=10, psel=0.
// - Read with miso_start before pready -> err_code=11; penable stays until pready; cs_n_o=1
//   then -> IDLE.
// - Index 5 with NSLV=4 -> no psel asserted, err_code=01. Reset asserted in ACCESS -> all
//   outputs 0 immediately.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-APB bridge control block.
// - state_t  : control FSM state encoding
// - ERR_*    : err_code values
// - STAT_*   : status-frame field offsets above the slave-index field
// - sel_width: width of the slave-index field for a given slave count
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitWr,
        StSetupWr,
        StAccessWr,
        StSetupRd,
        StAccessRd,
        StWaitRd,
        StError
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SLV  = 2'b01;  // pslverr or out-of-range slave index
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_UNDR = 2'b11;  // MISO started before read data arrived

    // status = {write, burst, index[SEL_W-1:0]}
    localparam int unsigned STAT_BURST_OFS = 0;
    localparam int unsigned STAT_WRITE_OFS = 1;

    function automatic int unsigned sel_width(input int unsigned nslv);
        return (nslv > 1) ? $clog2(nslv) : 1;
    endfunction

endpackage

// File: rtl/apb_tmo_cnt.sv
// Access-phase timeout counter.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   i_clr        : hold the count at zero
//   i_en         : count one access cycle
//   o_expired    : count has reached TMO-1 (terminal access cycle)
module apb_tmo_cnt #(
    parameter int unsigned  TMO   = 64,
    localparam int unsigned CNT_W = $clog2(TMO)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    assign o_expired = (r_cnt == CNT_W'(TMO - 1));

    // Saturates at the terminal count so a held access never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_apb_bridge_ctrl.sv
// Control FSM between the SPI slave deserialiser and an APB3 master port.
// Decoded address/status/data frames become APB transfers to one of NSLV slaves.
// Ports:
//   clk, reset_n                     : clock, async active-low reset
//   address_ready/addr               : start address pulse + value
//   status_ready/status              : command pulse + {write, burst, slave index}
//   data_ready/wdata                 : write data valid / read data consumed
//   cs_n_o                           : SPI chip select, high ends the frame
//   miso_start                       : serialiser began shifting rdata out
//   pready/prdata/pslverr            : APB slave response
//   psel/penable/pwrite/pstrb/paddr/pwdata : APB request
//   rdata                            : data to the MISO serialiser (ERR_WORD in error)
//   err/err_code                     : error entry pulse, sticky error code
module spi_apb_bridge_ctrl
    import spi_bridge_pkg::*;
#(
    parameter int unsigned  ADDR_W   = 20,
    parameter int unsigned  DATA_W   = 16,
    parameter int unsigned  NSLV     = 2,
    parameter int unsigned  TMO      = 64,
    parameter logic [15:0]  ERR_WORD = 16'h4552,
    localparam int unsigned SEL_W    = sel_width(NSLV),
    localparam int unsigned STRB_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              address_ready,
    input  logic              status_ready,
    input  logic              data_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [SEL_W+1:0]  status,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cs_n_o,
    input  logic              miso_start,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic [NSLV-1:0]   pslverr,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    output logic              pwrite,
    output logic [STRB_W-1:0] pstrb,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_WORD);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRB_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_cs_flag;
    logic              r_underrun;
    logic              w_underrun_nxt;
    logic [1:0]        w_code_nxt;
    logic [SEL_W-1:0]  r_idx;
    logic              r_write;
    logic              r_burst;

    logic [SEL_W-1:0]  w_st_idx;
    logic              w_st_write;
    logic              w_st_burst;
    logic              w_start;
    logic              w_idx_ok;
    logic [SEL_W-1:0]  w_idx;
    logic [NSLV-1:0]   w_sel_1h;
    logic              w_slverr;
    logic              w_in_access;
    logic              w_tmo_clr;
    logic              w_tmo_exp;
    logic              w_apb_nxt;

    assign w_st_idx    = status[SEL_W-1:0];
    assign w_st_write  = status[SEL_W + STAT_WRITE_OFS];
    assign w_st_burst  = status[SEL_W + STAT_BURST_OFS];
    assign w_start     = (r_state == StIdle) && status_ready;
    assign w_idx_ok    = (32'(w_st_idx) < NSLV);
    // A command starting from IDLE may go straight to SETUP_RD, so use the live index.
    assign w_idx       = w_start ? w_st_idx : r_idx;
    assign w_in_access = (r_state == StAccessWr) || (r_state == StAccessRd);
    assign w_tmo_clr   = !w_in_access;

    apb_tmo_cnt #(
        .TMO(TMO)
    ) u_tmo_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (w_tmo_clr),
        .i_en     (w_in_access),
        .o_expired(w_tmo_exp)
    );

    always_comb begin
        w_sel_1h = '0;
        w_slverr = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            w_sel_1h[i] = (w_idx == SEL_W'(i));
            if (r_idx == SEL_W'(i)) begin
                w_slverr = pslverr[i];
            end
        end
    end

    // address_ready has priority over the post-beat increment.
    always_comb begin
        w_addr_nxt = r_addr;
        if (address_ready) begin
            w_addr_nxt = addr;
        end else if (w_in_access && pready) begin
            w_addr_nxt = r_addr + ADDR_STEP;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = err_code;
        w_underrun_nxt = r_underrun;
        unique case (r_state)
            StIdle: begin
                if (status_ready) begin
                    w_code_nxt = ERR_NONE;
                    if (!w_idx_ok) begin
                        w_state_nxt = StError;
                        w_code_nxt  = ERR_SLV;
                    end else if (w_st_write) begin
                        w_state_nxt = StWaitWr;
                    end else begin
                        w_state_nxt = StSetupRd;
                    end
                end
            end
            StWaitWr: begin
                if (r_cs_flag) begin
                    w_state_nxt = StIdle;
                end else if (data_ready) begin
                    w_state_nxt = StSetupWr;
                end
            end
            StSetupWr: w_state_nxt = StAccessWr;
            StSetupRd: w_state_nxt = StAccessRd;
            StAccessWr, StAccessRd: begin
                // pready beats the terminal count.
                if (pready) begin
                    if (w_slverr) begin
                        w_state_nxt = StError;
                        w_code_nxt  = ERR_SLV;
                    end else if (r_state == StAccessRd) begin
                        // Underrun code was latched when it was detected.
                        w_state_nxt = r_underrun ? StError : StWaitRd;
                    end else if (r_burst && !r_cs_flag) begin
                        w_state_nxt = StWaitWr;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else if (w_tmo_exp) begin
                    w_state_nxt = StError;
                    w_code_nxt  = ERR_TMO;
                end else if ((r_state == StAccessRd) && miso_start) begin
                    // Report now, but keep the APB access alive until it resolves.
                    w_underrun_nxt = 1'b1;
                    w_code_nxt     = ERR_UNDR;
                end
            end
            StWaitRd: begin
                if (r_cs_flag) begin
                    w_state_nxt = StIdle;
                end else if (data_ready) begin
                    w_state_nxt = r_burst ? StSetupRd : StIdle;
                end
            end
            StError: begin
                if (r_cs_flag) begin
                    w_state_nxt = StIdle;
                end else if (data_ready) begin
                    if (!r_burst) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt = r_write ? StSetupWr : StSetupRd;
                    end
                end
            end
        endcase
        if (w_state_nxt != StAccessRd) begin
            w_underrun_nxt = 1'b0;
        end
    end

    assign w_apb_nxt = (w_state_nxt == StSetupWr) || (w_state_nxt == StAccessWr) ||
                       (w_state_nxt == StSetupRd) || (w_state_nxt == StAccessRd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_cs_flag  <= 1'b0;
            r_underrun <= 1'b0;
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_burst    <= 1'b0;
            psel       <= '0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pstrb      <= '0;
            paddr      <= '0;
            pwdata     <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_cs_flag  <= (r_state == StIdle) ? 1'b0 : (r_cs_flag | cs_n_o);
            r_underrun <= w_underrun_nxt;
            if (w_start) begin
                r_idx   <= w_st_idx;
                r_write <= w_st_write;
                r_burst <= w_st_burst;
            end
            psel    <= w_apb_nxt ? w_sel_1h : '0;
            penable <= (w_state_nxt == StAccessWr) || (w_state_nxt == StAccessRd);
            pstrb   <= w_apb_nxt ? {STRB_W{1'b1}} : '0;
            if (w_state_nxt == StSetupWr) begin
                pwrite <= 1'b1;
                pwdata <= wdata;
                paddr  <= w_addr_nxt;
            end else if (w_state_nxt == StSetupRd) begin
                pwrite <= 1'b0;
                paddr  <= w_addr_nxt;
            end
            if (w_state_nxt == StError) begin
                rdata <= ERR_RDATA;
            end else if ((r_state == StAccessRd) && (w_state_nxt == StWaitRd)) begin
                rdata <= prdata;
            end
            err      <= (w_state_nxt == StError) && (r_state != StError);
            err_code <= w_code_nxt;
        end
    end

endmodule

// File: tb/tb_spi_apb_bridge_ctrl.sv
// Self-checking bench for spi_apb_bridge_ctrl. The bench plays both the SPI frame
// decoder and the APB slaves; a transaction-level model predicts addresses, select,
// read data and error codes for each beat.
module tb_spi_apb_bridge_ctrl;

    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned DATA_W   = 16;
    // Five slaves so that indices 5..7 are out-of-range decodes.
    localparam int unsigned NSLV     = 5;
    localparam int unsigned TMO      = 8;
    localparam logic [15:0] ERR_WORD = 16'h4552;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              address_ready, status_ready, data_ready;
    logic [ADDR_W-1:0] addr;
    logic [4:0]        status;
    logic [DATA_W-1:0] wdata;
    logic              cs_n_o, miso_start, pready;
    logic [DATA_W-1:0] prdata;
    logic [NSLV-1:0]   pslverr;
    logic [NSLV-1:0]   psel;
    logic              penable, pwrite;
    logic [1:0]        pstrb;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata, rdata;
    logic              err;
    logic [1:0]        err_code;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-beat stimulus for the next transaction.
    int          bw[4];     // access cycles with pready low; >= TMO means timeout
    bit          bserr[4];
    bit          bundr[4];
    logic [15:0] bwd[4];
    bit          ld_en = 1'b0;  // pulse address_ready together with pready
    logic [19:0] ld_addr = '0;

    always #5 clk = ~clk;

    spi_apb_bridge_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NSLV    (NSLV),
        .TMO     (TMO),
        .ERR_WORD(ERR_WORD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address_ready(address_ready),
        .status_ready (status_ready),
        .data_ready   (data_ready),
        .addr         (addr),
        .status       (status),
        .wdata        (wdata),
        .cs_n_o       (cs_n_o),
        .miso_start   (miso_start),
        .pready       (pready),
        .prdata       (prdata),
        .pslverr      (pslverr),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .pstrb        (pstrb),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .rdata        (rdata),
        .err          (err),
        .err_code     (err_code)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NSLV-1:0] onehot(input int i);
        logic [NSLV-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Entered with the DUT just in SETUP; returns with the beat resolved.
    task automatic do_beat(input bit wr, input int idx, input logic [19:0] exp_addr,
                           input logic [15:0] exp_wd, input int wait_n, input bit serr,
                           input bit undr, output logic [15:0] rd_val);
        check_eq("setup_psel", psel, onehot(idx));
        check_eq("setup_penable", penable, 0);
        check_eq("setup_paddr", paddr, exp_addr);
        check_eq("setup_pwrite", pwrite, wr);
        if (wr) check_eq("setup_pwdata", pwdata, exp_wd);
        check_eq("setup_pstrb", pstrb, 2'b11);
        check_eq("setup_err", err, 0);
        rd_val = 16'($urandom);
        tick();
        for (int i = 0; i < wait_n && i < int'(TMO); i++) begin
            check_eq("access_penable", penable, 1);
            check_eq("access_psel", psel, onehot(idx));
            if (undr && i == 0) miso_start = 1'b1;
            tick();
            miso_start = 1'b0;
            if (undr && i == 0) begin
                check_eq("undr_code", err_code, 2'b11);
                check_eq("undr_err", err, 0);
            end
        end
        if (wait_n < int'(TMO)) begin
            check_eq("ready_penable", penable, 1);
            pready  = 1'b1;
            prdata  = rd_val;
            pslverr = NSLV'($urandom) & ~onehot(idx);
            if (serr) pslverr = pslverr | onehot(idx);
            address_ready = ld_en;
            addr          = ld_addr;
            tick();
            pready        = 1'b0;
            pslverr       = '0;
            address_ready = 1'b0;
        end
    endtask

    task automatic run_txn(input bit wr, input bit burst, input int idx, input logic [19:0] a,
                           input int nb, input bit send_a, input bit end_by_data);
        logic [19:0] cur;
        logic [1:0]  code;
        logic [15:0] rv;
        bit          bad;
        cur  = a;
        code = 2'b00;
        if (send_a) begin
            address_ready = 1'b1;
            addr          = a;
            tick();
            address_ready = 1'b0;
        end
        status       = {wr, burst, 3'(idx)};
        status_ready = 1'b1;
        tick();
        status_ready = 1'b0;
        if (idx >= int'(NSLV)) begin
            check_eq("dec_err", err, 1);
            check_eq("dec_code", err_code, 2'b01);
            check_eq("dec_psel", psel, 0);
            check_eq("dec_rdata", rdata, ERR_WORD);
        end else begin
            check_eq("start_code", err_code, 2'b00);
            for (int b = 0; b < nb; b++) begin
                if (wr || b > 0) begin
                    data_ready = 1'b1;
                    wdata      = bwd[b];
                    tick();
                    data_ready = 1'b0;
                end
                do_beat(wr, idx, cur, bwd[b], bw[b], bserr[b], bundr[b], rv);
                bad = (bw[b] >= int'(TMO)) || bserr[b] || bundr[b];
                if (bw[b] >= int'(TMO)) begin
                    code = 2'b10;
                end else begin
                    cur = cur + 20'd2;
                    if (bserr[b]) code = 2'b01;
                    else if (bundr[b]) code = 2'b11;
                end
                check_eq("post_err", err, bad);
                check_eq("post_code", err_code, code);
                check_eq("post_psel", psel, 0);
                check_eq("post_penable", penable, 0);
                if (bad) check_eq("post_rdata_err", rdata, ERR_WORD);
                else if (!wr) check_eq("post_rdata", rdata, rv);
            end
        end
        if (end_by_data && !burst) begin
            data_ready = 1'b1;
            tick();
            data_ready = 1'b0;
        end else begin
            cs_n_o = 1'b1;
            tick();
            tick();
            cs_n_o = 1'b0;
        end
        tick();
        check_eq("end_psel", psel, 0);
        check_eq("end_penable", penable, 0);
    endtask

    task automatic clear_beats();
        for (int i = 0; i < 4; i++) begin
            bw[i]    = 0;
            bserr[i] = 1'b0;
            bundr[i] = 1'b0;
            bwd[i]   = 16'($urandom);
        end
    endtask

    initial begin
        bit          wr, burst;
        int          idx, nb;
        logic [19:0] a;
        reset_n = 1'b0;
        address_ready = 1'b0; status_ready = 1'b0; data_ready = 1'b0;
        addr = '0; status = '0; wdata = '0; cs_n_o = 1'b0; miso_start = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_psel", psel, 0);
        check_eq("rst_penable", penable, 0);
        check_eq("rst_pwrite", pwrite, 0);
        check_eq("rst_pstrb", pstrb, 0);
        check_eq("rst_paddr", paddr, 0);
        check_eq("rst_pwdata", pwdata, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_code", err_code, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single write, slave 2.
        clear_beats();
        bwd[0] = 16'hA5A5;
        run_txn(1'b1, 1'b0, 2, 20'h00100, 1, 1'b1, 1'b0);

        // Burst read x3 with three wait cycles each.
        clear_beats();
        bw[0] = 3; bw[1] = 3; bw[2] = 3;
        run_txn(1'b0, 1'b1, 1, 20'h00010, 3, 1'b1, 1'b0);

        // Slave error on the first beat of a burst write; burst resumes at addr+2.
        clear_beats();
        bserr[0] = 1'b1; bw[1] = 1;
        run_txn(1'b1, 1'b1, 1, 20'h00400, 2, 1'b1, 1'b0);

        // Timeout, then the burst retries the same address.
        clear_beats();
        bw[0] = TMO;
        run_txn(1'b1, 1'b1, 0, 20'h00800, 2, 1'b1, 1'b0);

        // pready exactly on the terminal count.
        clear_beats();
        bw[0] = TMO - 1;
        run_txn(1'b0, 1'b0, 4, 20'h01230, 1, 1'b1, 1'b1);

        // Read underrun: access held until pready.
        clear_beats();
        bw[0] = 4; bundr[0] = 1'b1;
        run_txn(1'b0, 1'b0, 0, 20'h02000, 1, 1'b1, 1'b0);

        // Out-of-range slave index.
        clear_beats();
        run_txn(1'b1, 1'b0, 5, 20'h03000, 1, 1'b1, 1'b0);

        // address_ready coinciding with pready overrides the increment.
        clear_beats();
        bw[0] = 2; ld_en = 1'b1; ld_addr = 20'h0ABCD;
        run_txn(1'b1, 1'b0, 3, 20'h00200, 1, 1'b1, 1'b0);
        ld_en = 1'b0;
        clear_beats();
        run_txn(1'b0, 1'b0, 4, 20'h0ABCD, 1, 1'b0, 1'b1);

        // Address wrap at the top of the space.
        clear_beats();
        run_txn(1'b1, 1'b1, 2, 20'hFFFFE, 3, 1'b1, 1'b0);

        // Reset in the middle of an access phase.
        address_ready = 1'b1; addr = 20'h00500; tick(); address_ready = 1'b0;
        status = {1'b1, 1'b0, 3'd0}; status_ready = 1'b1; tick(); status_ready = 1'b0;
        data_ready = 1'b1; wdata = 16'h1234; tick(); data_ready = 1'b0;
        tick();
        check_eq("pre_rst_penable", penable, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_psel", psel, 0);
        check_eq("mid_rst_penable", penable, 0);
        check_eq("mid_rst_pwrite", pwrite, 0);
        check_eq("mid_rst_paddr", paddr, 0);
        check_eq("mid_rst_pstrb", pstrb, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            clear_beats();
            wr    = 1'($urandom_range(0, 1));
            burst = 1'($urandom_range(0, 1));
            nb    = burst ? int'($urandom_range(1, 3)) : 1;
            idx   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7))
                                                : int'($urandom_range(0, 4));
            a     = ($urandom_range(0, 3) == 0) ? 20'hFFFFA + 20'(2 * $urandom_range(0, 2))
                                                : 20'($urandom);
            for (int b = 0; b < nb; b++) begin
                bw[b]    = int'($urandom_range(0, TMO));
                bserr[b] = ($urandom_range(0, 7) == 0);
                bundr[b] = !wr && !bserr[b] && bw[b] >= 1 && bw[b] < int'(TMO) &&
                           ($urandom_range(0, 5) == 0);
            end
            run_txn(wr, burst, idx, a, nb, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
